// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: drives a req/ready + rvalid data bus, formats store lanes,
// extracts/extends load data, stalls the pipeline and reports misaligned/illegal/timeout errors.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_addr,
  output logic        err_valid,
  output logic [1:0]  err_cause
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [1:0]       r_off;
  logic [4:0]       r_rd_addr;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [31:0]      r_bus_wdata;
  logic [3:0]       r_bus_wstrb;
  logic             r_wb_valid;
  logic [31:0]      r_wb_data;
  logic [4:0]       r_wb_rd_addr;
  logic             r_err_valid;
  logic [1:0]       r_err_cause;

  logic        w_we;
  logic        w_re;
  logic [2:0]  w_op;
  logic        w_start;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_limit;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_strb;
  logic [31:0] w_lane;
  logic [31:0] w_ld_data;

  assign w_we    = mem_op[4];
  assign w_re    = mem_op[3];
  assign w_op    = mem_op[2:0];
  assign w_start = in_valid & (r_state == StIdle) & (w_we | w_re);

  // Stores have no unsigned variants, so op[2] on a store is illegal.
  assign w_illegal = (w_we & w_re) | (w_op == 3'b011) | (w_op == 3'b110) | (w_op == 3'b111) |
                     (w_we & w_op[2]);
  assign w_misalign = ((w_op[1:0] == 2'b01) & addr[0]) |
                      ((w_op == 3'b010) & (addr[1:0] != 2'b00));

  assign w_limit = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_st_data = wdata;
    w_st_strb = 4'b1111;
    case (w_op[1:0])
      2'b00: begin
        w_st_data = {4{wdata[7:0]}};
        w_st_strb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_st_data = {2{wdata[15:0]}};
        w_st_strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!w_we) w_st_strb = 4'b0000;
  end

  assign w_lane = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_op)
      3'b000:  w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_ld_data = {24'h0, w_lane[7:0]};
      3'b001:  w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_ld_data = {16'h0, w_lane[15:0]};
      default: w_ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_op         <= '0;
      r_off        <= '0;
      r_rd_addr    <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_wstrb  <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rd_addr <= '0;
      r_err_valid  <= 1'b0;
      r_err_cause  <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_err_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            if (w_illegal) begin
              r_err_valid <= 1'b1;
              r_err_cause <= 2'b10;
            end else if (w_misalign) begin
              r_err_valid <= 1'b1;
              r_err_cause <= 2'b01;
            end else begin
              r_state     <= StReq;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= w_we;
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_wdata <= w_st_data;
              r_bus_wstrb <= w_st_strb;
              r_rd_addr   <= rd_addr;
              r_op        <= w_op;
              r_off       <= addr[1:0];
            end
          end
        end
        StReq: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Acceptance on the limit cycle still completes normally.
          if (bus_ready) begin
            r_bus_req <= 1'b0;
            r_state   <= r_bus_we ? StIdle : StResp;
          end else if (w_limit) begin
            r_bus_req   <= 1'b0;
            r_state     <= StIdle;
            r_err_valid <= 1'b1;
            r_err_cause <= 2'b11;
          end
        end
        StResp: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus_rvalid) begin
            r_state      <= StIdle;
            r_wb_valid   <= 1'b1;
            r_wb_data    <= w_ld_data;
            r_wb_rd_addr <= r_rd_addr;
          end else if (w_limit) begin
            r_state     <= StIdle;
            r_err_valid <= 1'b1;
            r_err_cause <= 2'b11;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign stall      = ~rst & (w_start | (r_state != StIdle));
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wstrb  = r_bus_wstrb;
  assign wb_valid   = r_wb_valid;
  assign wb_data    = r_wb_data;
  assign wb_rd_addr = r_wb_rd_addr;
  assign err_valid  = r_err_valid;
  assign err_cause  = r_err_cause;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl: stores, loads, errors, timeout and reset.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_addr;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic        err_valid;
  logic [1:0]  err_cause;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .mem_op     (mem_op),
    .addr       (addr),
    .wdata      (wdata),
    .rd_addr    (rd_addr),
    .stall      (stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd_addr (wb_rd_addr),
    .err_valid  (err_valid),
    .err_cause  (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; mem_op = 5'b10010; addr = 32'h104; wdata = 32'h1;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_tests++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus_req); end
    n_tests++; if (bus_addr !== 32'h0 || bus_wstrb !== 4'h0 || bus_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h strb=%h we=%b want 0", bus_addr, bus_wstrb, bus_we);
    end
    n_tests++; if (wb_valid !== 1'b0 || err_valid !== 1'b0 || wb_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_pulses: wbv=%b errv=%b wbd=%h want 0", wb_valid, err_valid, wb_data);
    end
    next();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: stall=%b req=%b want 0", stall, bus_req);
    end
  endtask

  task automatic test_store(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_wd,
                            input logic [3:0] exp_strb, input int delay);
    next();
    in_valid = 1'b1; mem_op = {2'b10, op}; addr = a; wdata = wd; rd_addr = 5'd0;
    bus_ready = 1'b1; bus_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL %s_start: stall=%b req=%b want 1/0", name, stall, bus_req);
    end
    for (int d = 0; d <= delay; d++) begin
      next();
      in_valid = 1'b0; bus_ready = (d == delay);
      @(negedge clk);
      n_tests++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || stall !== 1'b1) begin
        n_fail++; $display("FAIL %s_req%0d: req=%b we=%b stall=%b want 1", name, d, bus_req, bus_we, stall);
      end
      n_tests++; if (bus_addr !== {a[31:2], 2'b00} || bus_wdata !== exp_wd || bus_wstrb !== exp_strb) begin
        n_fail++;
        $display("FAIL %s_bus%0d: addr=%h wd=%h strb=%b want %h %h %b", name, d, bus_addr, bus_wdata,
                 bus_wstrb, {a[31:2], 2'b00}, exp_wd, exp_strb);
      end
    end
    next();
    bus_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || bus_req !== 1'b0 || err_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_done: stall=%b req=%b err=%b want 0", name, stall, bus_req, err_valid);
    end
  endtask

  task automatic test_load(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp);
    next();
    in_valid = 1'b1; mem_op = {2'b01, op}; addr = a; wdata = 32'hFFFF_FFFF; rd_addr = rd;
    bus_ready = 1'b1; bus_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_start: stall=%b want 1", name, stall); end
    next();
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_wstrb !== 4'b0000 ||
                   bus_addr !== {a[31:2], 2'b00} || stall !== 1'b1) begin
      n_fail++; $display("FAIL %s_req: req=%b we=%b strb=%b addr=%h stall=%b", name, bus_req, bus_we,
                         bus_wstrb, bus_addr, stall);
    end
    next();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1 || bus_req !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_resp: stall=%b req=%b wbv=%b want 1/0/0", name, stall, bus_req, wb_valid);
    end
    next();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || wb_valid !== 1'b1 || wb_data !== exp || wb_rd_addr !== rd) begin
      n_fail++; $display("FAIL %s_wb: stall=%b wbv=%b data=%h rd=%0d want 0/1/%h/%0d", name, stall,
                         wb_valid, wb_data, wb_rd_addr, exp, rd);
    end
    next();
    @(negedge clk);
    n_tests++; if (wb_valid !== 1'b0 || wb_data !== exp) begin
      n_fail++; $display("FAIL %s_hold: wbv=%b data=%h want 0/%h", name, wb_valid, wb_data, exp);
    end
  endtask

  task automatic test_err(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [1:0] exp_cause);
    next();
    in_valid = 1'b1; mem_op = op; addr = a; bus_ready = 1'b1; bus_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL %s_start: stall=%b req=%b want 1/0", name, stall, bus_req);
    end
    next();
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (err_valid !== 1'b1 || err_cause !== exp_cause || bus_req !== 1'b0 ||
                   stall !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_err: errv=%b cause=%b req=%b stall=%b want 1/%b/0/0", name,
                         err_valid, err_cause, bus_req, stall, exp_cause);
    end
    next();
    bus_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (err_valid !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL %s_after: errv=%b req=%b want 0", name, err_valid, bus_req);
    end
  endtask

  task automatic test_noop();
    next();
    in_valid = 1'b1; mem_op = 5'b00010; addr = 32'h100;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL noop_stall: got %b want 0", stall); end
    next();
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus_req !== 1'b0 || err_valid !== 1'b0) begin
      n_fail++; $display("FAIL noop_bus: req=%b errv=%b want 0", bus_req, err_valid);
    end
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    bit seen = 1'b0;
    next();
    in_valid = 1'b1; mem_op = 5'b01010; addr = 32'h500; rd_addr = 5'd4;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      next();
      in_valid = 1'b0;
      @(negedge clk);
      if (bus_req) req_cnt++;
      if (err_valid) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL timeout_seen: no error pulse within 40 cycles"); end
    n_tests++; if (req_cnt != 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 16", req_cnt); end
    n_tests++; if (err_cause !== 2'b11 || stall !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err: cause=%b stall=%b req=%b want 11/0/0", err_cause, stall, bus_req);
    end
    next();
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    next();
    bus_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (wb_valid !== 1'b0 || stall !== 1'b0 || err_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_late_rvalid: wbv=%b stall=%b errv=%b want 0", wb_valid, stall, err_valid);
    end
  endtask

  task automatic test_timeout_tie();
    int req_cnt = 0;
    next();
    in_valid = 1'b1; mem_op = 5'b10010; addr = 32'h700; wdata = 32'h5555_AAAA;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    for (int d = 0; d < 16; d++) begin
      next();
      in_valid = 1'b0; bus_ready = (d == 15);
      @(negedge clk);
      if (bus_req) req_cnt++;
    end
    n_tests++; if (req_cnt != 16) begin n_fail++; $display("FAIL tie_req_cycles: got %0d want 16", req_cnt); end
    next();
    bus_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (err_valid !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL tie_done: errv=%b stall=%b req=%b want 0", err_valid, stall, bus_req);
    end
  endtask

  task automatic test_reset_mid();
    next();
    in_valid = 1'b1; mem_op = 5'b01101; addr = 32'h402; rd_addr = 5'd3;
    bus_ready = 1'b1; bus_rvalid = 1'b0;
    next();
    in_valid = 1'b0;
    next();
    bus_ready = 1'b0; rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h8001_1234;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 ||
                   bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
      n_fail++; $display("FAIL midrst_bus: stall=%b req=%b we=%b addr=%h wd=%h strb=%b want 0", stall,
                         bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb);
    end
    n_tests++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_rd_addr !== 5'd0 ||
                   err_valid !== 1'b0 || err_cause !== 2'b00) begin
      n_fail++; $display("FAIL midrst_out: wbv=%b wbd=%h rd=%0d errv=%b cause=%b want 0", wb_valid,
                         wb_data, wb_rd_addr, err_valid, err_cause);
    end
    next();
    rst = 1'b0;
    @(negedge clk);
    next();
    bus_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: wbv=%b stall=%b want 0", wb_valid, stall);
    end
    test_store("sw_after_rst", 3'b010, 32'h108, 32'h0123_4567, 32'h0123_4567, 4'b1111, 0);
  endtask

  initial begin
    in_valid = 1'b0; mem_op = 5'b0; addr = 32'h0; wdata = 32'h0; rd_addr = 5'd0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; rst = 1'b1;
    test_reset();
    test_store("sw", 3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 0);
    test_store("sb", 3'b000, 32'h203, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000, 2);
    test_store("sb0", 3'b000, 32'h200, 32'h1234_5677, 32'h7777_7777, 4'b0001, 0);
    test_store("sh", 3'b001, 32'h106, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100, 1);
    test_load("lb", 3'b000, 32'h302, 5'd7, 32'h1280_FF34, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h302, 5'd9, 32'h1280_FF34, 32'h0000_0080);
    test_load("lb1", 3'b000, 32'h301, 5'd0, 32'h1280_FF34, 32'hFFFF_FFFF);
    test_load("lh", 3'b001, 32'h402, 5'd12, 32'h8001_1234, 32'hFFFF_8001);
    test_load("lhu", 3'b101, 32'h402, 5'd13, 32'h8001_1234, 32'h0000_8001);
    test_load("lw", 3'b010, 32'h600, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D);
    test_err("lh_mis", 5'b01001, 32'h101, 2'b01);
    test_err("lw_mis", 5'b01010, 32'h102, 2'b01);
    test_err("sh_mis", 5'b10001, 32'h103, 2'b01);
    test_err("rw_ill", 5'b11010, 32'h100, 2'b10);
    test_err("rw_ill_prio", 5'b11001, 32'h101, 2'b10);
    test_err("sbu_ill", 5'b10100, 32'h100, 2'b10);
    test_err("op011_ill", 5'b01011, 32'h100, 2'b10);
    test_noop();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
